// File: rtl/div_iter.sv
// div_iter: iterative 32-bit restoring divider, signed (DIV) or unsigned (DIVU).
// One quotient bit per cycle; a single divide takes 35 cycles from start to done.
//
// Ports:
//   clk        - clock, rising edge
//   resetn     - asynchronous active-low reset
//   start      - request a divide (sampled only while idle)
//   is_signed  - 1 = signed operands, 0 = unsigned (captured with start)
//   cancel     - abort the in-flight divide, return to idle
//   a, b       - dividend, divisor (captured with start)
//   busy       - divide in progress (CALC/FIX)
//   done       - one-cycle pulse, quotient/remainder just updated
//   quotient   - last completed quotient (LO)
//   remainder  - last completed remainder (HI)
module div_iter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        is_signed,
    input  logic        cancel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_nx;

    logic           load_c;
    logic           step_c;
    logic           commit_c;

    logic [CW-1:0]  cnt;
    logic [W:0]     pr;       // partial remainder
    logic [W-1:0]   dq;       // dividend shifts out the top, quotient shifts in the bottom
    logic [W-1:0]   bm;       // divisor magnitude
    logic           q_neg;
    logic           r_neg;
    logic           b_zero;

    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic [W:0]     shifted;
    logic [W:0]     diff;
    logic [W-1:0]   q_fix;
    logic [W-1:0]   r_fix;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        state_nx = state;
        load_c   = 1'b0;
        step_c   = 1'b0;
        commit_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !cancel) begin
                    load_c   = 1'b1;
                    state_nx = S_CALC;
                end
            end
            S_CALC: begin
                if (cancel) begin
                    state_nx = S_IDLE;
                end else begin
                    step_c = 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        state_nx = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (cancel) begin
                    state_nx = S_IDLE;
                end else begin
                    commit_c = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Operand magnitudes; 0x80000000 stays 0x80000000, read as unsigned
    assign a_mag = (is_signed && a[W-1]) ? (~a + W'(1)) : a;
    assign b_mag = (is_signed && b[W-1]) ? (~b + W'(1)) : b;

    // One restoring step: shift in next dividend bit, trial-subtract the divisor
    assign shifted = (pr << 1) | (W + 1)'(dq[W-1]);
    assign diff    = shifted + {1'b1, ~bm} + (W + 1)'(1);

    // Sign fix-up; a zero divisor yields all-ones and the original dividend
    // (negating the remainder magnitude of a negative dividend restores it)
    assign q_fix = b_zero ? '1 : (q_neg ? (~dq + W'(1)) : dq);
    assign r_fix = r_neg ? (~pr[W-1:0] + W'(1)) : pr[W-1:0];

    // Iteration datapath
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt    <= '0;
            pr     <= '0;
            dq     <= '0;
            bm     <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            b_zero <= 1'b0;
        end else if (load_c) begin
            cnt    <= '0;
            pr     <= '0;
            dq     <= a_mag;
            bm     <= b_mag;
            q_neg  <= is_signed & (a[W-1] ^ b[W-1]);
            r_neg  <= is_signed & a[W-1];
            b_zero <= (b == '0);
        end else if (step_c) begin
            cnt <= cnt + CW'(1);
            pr  <= diff[W] ? shifted : diff;
            dq  <= {dq[W-2:0], ~diff[W]};
        end
    end

    // Result registers, written only on a completed divide
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            quotient  <= '0;
            remainder <= '0;
        end else if (commit_c) begin
            quotient  <= q_fix;
            remainder <= r_fix;
        end
    end

    // Registered status, decoded from the next state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nx == S_CALC) || (state_nx == S_FIX);
            done <= (state_nx == S_DONE);
        end
    end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 resetn  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  request a divide; sampled only when idle.
REQ-004 is_signed  input  1  1 = signed (DIV), 0 = unsigned (DIVU); captured with start.
REQ-005 cancel  input  1  abort in-flight divide (pipeline flush/exception).
REQ-006 a  input  32  dividend; captured with start.
REQ-007 b  input  32  divisor; captured with start.
REQ-008 busy  output  1  high while a divide is in progress.
REQ-009 done  output  1  one-cycle pulse; quotient/remainder valid.
REQ-010 quotient  output  32  result quotient (HI/LO write source: LO).
REQ-011 remainder  output  32  result remainder (HI).

Function
REQ-012 The FSM SHALL have states IDLE, CALC, FIX, DONE.
REQ-013 IDLE: start=1 and cancel=0 SHALL capture a, b and is_signed, load magnitudes (two's-complement absolute value if is_signed, else raw), clear the 6-bit iteration counter and the 33-bit partial remainder, and go to CALC.
REQ-014 CALC SHALL perform one restoring step per cycle: shift the partial remainder left by one, shifting in the next dividend MSB; compute the trial difference as partial remainder plus ~divisor with carry-in 1 (33-bit); if non-negative, keep the difference and shift 1 into the quotient, else restore and shift 0.
REQ-015 CALC SHALL last exactly 32 cycles (counter 0..31), then go to FIX.
REQ-016 FIX: signed mode SHALL negate the quotient when the operand signs differ and negate the remainder when the dividend is negative; unsigned mode passes values through; then go to DONE.
REQ-017 DONE: quotient/remainder registers SHALL be updated, done=1 for exactly this one cycle, and the FSM SHALL go to IDLE.
REQ-018 Latency: with start sampled in cycle 0, busy SHALL be high in cycles 1..33 and done high in cycle 34 only.
REQ-019 quotient and remainder SHALL hold their last values until the next completed divide; they SHALL NOT change during CALC/FIX.
REQ-020 start while busy SHALL be ignored; the next start is accepted in the cycle after done (the IDLE cycle); back-to-back issue has a minimum spacing of 35 cycles.
REQ-021 cancel=1 in CALC, FIX or DONE SHALL force IDLE at the next edge; done SHALL NOT assert for the cancelled divide; outputs are left unchanged.
REQ-022 cancel and start high together in IDLE: cancel wins; no divide starts.
REQ-023 b=0 (either mode) SHALL produce quotient=0xFFFFFFFF and remainder=a (original operand), with the same latency and the sign fix skipped.
REQ-024 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient=0x80000000, remainder=0 (no trap; overflow is wrap-around).
REQ-025 Signed magnitude of 0x80000000 SHALL be 0x80000000 treated as unsigned (33-bit datapath, no overflow).

Reset
REQ-026 resetn=0 SHALL immediately, regardless of clk, force IDLE, busy=0, done=0, quotient=0, remainder=0, counter=0 and partial remainder=0.
REQ-027 Reset asserted mid-divide SHALL discard the operation; after release the block SHALL accept a start on the first rising edge.

Verification
REQ-028 Unsigned a=100, b=7, start in cycle 0 -> done in cycle 34 only, quotient=14, remainder=2; busy high in cycles 1..33.
REQ-029 Signed a=0xFFFFFFF9 (-7), b=2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); signed a=7, b=0xFFFFFFFE -> quotient=0xFFFFFFFD, remainder=1.
REQ-030 Signed a=0x80000000, b=0xFFFFFFFF -> quotient=0x80000000, remainder=0; unsigned a=0xFFFFFFFF, b=1 -> quotient=0xFFFFFFFF, remainder=0.
REQ-031 Unsigned a=5, b=0 and signed a=0xFFFFFFFB, b=0 -> quotient=0xFFFFFFFF, remainder=a, done in cycle 34.
REQ-032 Start 100/7, cancel in cycle 10 -> busy=0 from cycle 11, no done, outputs unchanged; then start 9/3 with start re-pulsed mid-op -> single done, quotient=3, remainder=0.
REQ-033 resetn pulsed low in cycle 20 of a divide -> outputs 0 asynchronously, no done; start on the first edge after release -> correct result 34 cycles later.
